// File: rtl/pc_seq.sv
// Program-counter sequencer with increment/jump/branch/call/return/hold modes
// and a LIFO return-address stack with sticky overflow/underflow flags.
module pc_seq #(
  parameter int                 ADDR_W    = 8,
  parameter int                 RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
  input  logic              clk_pc,
  input  logic              rst_pc,
  input  logic              write_pc,
  input  logic [2:0]        pc_mode,
  input  logic [ADDR_W-1:0] cBusData,
  output logic [ADDR_W-1:0] addr_PC,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    MODE_INC  = 3'd0,
    MODE_JMP  = 3'd1,
    MODE_BRA  = 3'd2,
    MODE_CALL = 3'd3,
    MODE_RET  = 3'd4,
    MODE_HOLD = 3'd5
  } mode_e;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

  // Offset is relative to the current PC; the sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_branch(input logic [ADDR_W-1:0] pc,
                                                  input logic [ADDR_W-1:0] raw_off);
    logic signed [ADDR_W-1:0] off;
    off = signed'(raw_off);
    return pc + ADDR_W'(unsigned'(off));
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic              push_en;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              sp_empty;
  logic              sp_full;

  assign sp_empty = (sp_q == '0);
  assign sp_full  = (sp_q == SP_FULL);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (write_pc) begin
      case (pc_mode)
        MODE_JMP: pc_d = cBusData;
        MODE_BRA: pc_d = pc_branch(pc_q, cBusData);
        MODE_CALL: begin
          pc_d = cBusData;
          if (sp_full) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
          end
        end
        MODE_RET: begin
          if (sp_empty) begin
            pc_d  = pc_inc(pc_q);
            unf_d = 1'b1;
          end else begin
            pc_d = ras_q[pop_idx];
            sp_d = sp_q - SP_W'(1);
          end
        end
        MODE_HOLD: pc_d = pc_q;
        default:   pc_d = pc_inc(pc_q);
      endcase
    end
  end

  always_ff @(posedge clk_pc) begin
    if (rst_pc) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage is datapath: no reset, entries above sp are don't-care.
  always_ff @(posedge clk_pc) begin
    if (push_en) begin
      ras_q[push_idx] <= pc_inc(pc_q);
    end
  end

  assign addr_PC   = pc_q;
  assign ras_empty = sp_empty;
  assign ras_full  = sp_full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule
